// File: rtl/mag_sqrt_feeder.sv
// Squares incoming (x,y) pairs, queues the sums, and feeds them one at a time to an
// external iterative sqrt core. Optional WAIT watchdog: define MAG_FEEDER_TIMEOUT_EN.
module mag_sqrt_feeder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic        in_ready,
    input  logic [4:0]  cfg_iterations,
    output logic [31:0] sq_din,
    output logic        sq_start,
    output logic [4:0]  sq_iterations,
    input  logic [15:0] sq_dout,
    input  logic        sq_ready,
    input  logic        sq_busy,
    output logic [15:0] mag,
    output logic        mag_valid,
    output logic        timeout_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state_reg, state_next;

    logic signed [31:0] x_ext, y_ext, x_sq, y_sq;
    logic [31:0]        sum_sq;
    logic               accept;
    logic               sq_valid_reg;
    logic [31:0]        sq_val_reg;

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]        count_reg, count_next;
    logic               push, pop;

    logic [31:0]        din_reg;
    logic [15:0]        mag_reg;
    logic               mag_valid_reg;
    logic               timeout_hit;

    // Sign-extend before multiplying so (-32768)^2 lands correctly in 32 bits.
    assign x_ext  = 32'($signed(in_x));
    assign y_ext  = 32'($signed(in_y));
    assign x_sq   = x_ext * x_ext;
    assign y_sq   = y_ext * y_ext;
    assign sum_sq = $unsigned(x_sq) + $unsigned(y_sq);

    // The in-flight square stage counts against capacity so a push can never overflow.
    assign in_ready = rst_n && ((int'(count_reg) + int'(sq_valid_reg)) < FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = sq_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_valid_reg <= 1'b0;
            sq_val_reg   <= '0;
        end else begin
            sq_valid_reg <= accept;
            if (accept) begin
                sq_val_reg <= sum_sq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr_reg] <= sq_val_reg;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0 && !sq_busy) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (sq_ready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Head is presented combinationally during ISSUE; afterwards the copy in din_reg holds.
    always_comb begin
        sq_start = 1'b0;
        pop      = 1'b0;
        sq_din   = din_reg;
        if (state_reg == ISSUE) begin
            sq_start = 1'b1;
            pop      = 1'b1;
            sq_din   = fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_reg       <= '0;
            mag_reg       <= '0;
            mag_valid_reg <= 1'b0;
        end else begin
            mag_valid_reg <= 1'b0;
            if (state_reg == ISSUE) begin
                din_reg <= fifo_mem[rd_ptr_reg];
            end
            if (state_reg == WAIT && sq_ready) begin
                mag_reg       <= sq_dout;
                mag_valid_reg <= 1'b1;
            end
        end
    end

`ifdef MAG_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_reg;

    // Counter reads 0 in the first WAIT cycle, so expiry lands TIMEOUT_CYC cycles after ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == WAIT) && !sq_ready &&
                         (wait_cnt_reg == TW'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

    assign timeout_err   = timeout_hit;
    assign sq_iterations = cfg_iterations;
    assign mag           = mag_reg;
    assign mag_valid     = mag_valid_reg;

endmodule

// File: tb/tb_mag_sqrt_feeder.sv
// Self-checking bench for mag_sqrt_feeder with a behavioural sqrt core and a reference
// model of sum-of-squares / integer square root. Covers MAG_FEEDER_TIMEOUT_EN when defined.
`timescale 1ns/1ps
module tb_mag_sqrt_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_x, in_y;
    logic        in_ready;
    logic [4:0]  cfg_iterations;
    logic [31:0] sq_din;
    logic        sq_start;
    logic [4:0]  sq_iterations;
    logic [15:0] sq_dout;
    logic        sq_ready;
    logic        sq_busy;
    logic [15:0] mag;
    logic        mag_valid;
    logic        timeout_err;

    logic hold_busy, core_busy, core_en;
    int   core_lat;
    assign sq_busy = hold_busy | core_busy;

    always #5 clk = ~clk;

    mag_sqrt_feeder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_ready(in_ready), .cfg_iterations(cfg_iterations), .sq_din(sq_din),
        .sq_start(sq_start), .sq_iterations(sq_iterations), .sq_dout(sq_dout),
        .sq_ready(sq_ready), .sq_busy(sq_busy), .mag(mag), .mag_valid(mag_valid),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [31:0] model_sum(input logic signed [15:0] x, input logic signed [15:0] y);
        longint s;
        s = longint'(x) * longint'(x) + longint'(y) * longint'(y);
        return s[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, output bit ok, output int waited);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        waited   = 0;
        while (!in_ready && waited < 300) begin
            tick();
            waited++;
        end
        ok = in_ready;
        tick();
    endtask

    // Monitor: records every issue, result and timeout with its cycle number.
    int          cyc = 0;
    int          n_start = 0;
    int          n_to = 0;
    int          start_cyc = 0;
    int          to_cyc = 0;
    logic [31:0] din_q[$];
    logic [15:0] mag_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (sq_start) begin
                n_start++;
                din_q.push_back(sq_din);
                start_cyc = cyc;
            end
            if (mag_valid) mag_q.push_back(mag);
            if (timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end
        end
    end

    // Behavioural sqrt core: busy for core_lat cycles (random when 0), then one ready pulse.
    logic [31:0] core_op;
    int          core_wait;
    initial begin
        sq_ready  = 1'b0;
        sq_dout   = '0;
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (sq_start && core_en) begin
                core_op   = sq_din;
                core_wait = (core_lat > 0) ? core_lat : int'($urandom_range(1, 6));
                core_busy = 1'b1;
                repeat (core_wait) @(negedge clk);
                sq_dout   = 16'(isqrt(longint'(core_op)));
                sq_ready  = 1'b1;
                core_busy = 1'b0;
                @(negedge clk);
                sq_ready  = 1'b0;
            end
        end
    end

    task automatic wait_mags(input int n, input int lim);
        int k = 0;
        while (mag_q.size() < n && k < lim) begin
            tick();
            k++;
        end
        check("mag_count", 32'(mag_q.size()), 32'(n));
    endtask

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [31:0]        din;
        logic [15:0]        mag;
    } vec_t;
    vec_t vt[6];

    int          bx[4] = '{2, 0, 3, 6};
    int          by[4] = '{0, 4, 4, 8};
    int          bm[4] = '{2, 4, 5, 10};
    bit          ok;
    int          waited, s0, m0, d0, t0, k;
    logic [15:0] rx, ry;
    logic [4:0]  itv;
    logic [31:0] exp_q[$];

    initial begin
        vt[0] = '{16'sd3, 16'sd0, 32'd9, 16'd3};
        vt[1] = '{-16'sd3, 16'sd4, 32'd25, 16'd5};
        vt[2] = '{16'sh8000, 16'sh8000, 32'h8000_0000, 16'd46340};
        vt[3] = '{16'sd0, 16'sd0, 32'd0, 16'd0};
        vt[4] = '{16'sd6, -16'sd8, 32'd100, 16'd10};
        vt[5] = '{-16'sd1, -16'sd1, 32'd2, 16'd1};

        rst_n = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; cfg_iterations = '0;
        hold_busy = 1'b0; core_en = 1'b1; core_lat = 0;
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_sq_start", 32'(sq_start), 0);
        check("rst_sq_din", sq_din, 0);
        check("rst_mag", 32'(mag), 0);
        check("rst_mag_valid", 32'(mag_valid), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            itv = 5'($urandom);
            cfg_iterations = itv;
            tick();
            check("sq_iterations", 32'(sq_iterations), 32'(itv));
        end

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            s0 = n_start; m0 = mag_q.size(); d0 = din_q.size();
            send(vt[i].x, vt[i].y, ok, waited);
            in_valid = 1'b0;
            check("vec_accept", 32'(ok), 1);
            wait_mags(m0 + 1, 100);
            tick(3);
            check("vec_start_pulses", 32'(n_start - s0), 1);
            check("vec_sq_din", (din_q.size() > d0) ? din_q[d0] : 32'hFFFF_FFFF, vt[i].din);
            check("vec_din_hold", sq_din, vt[i].din);
            check("vec_mag", (mag_q.size() > m0) ? 32'(mag_q[m0]) : 32'hFFFF_FFFF, 32'(vt[i].mag));
            check("vec_mag_pulses", 32'(mag_q.size() - m0), 1);
            check("vec_mag_hold", 32'(mag), 32'(vt[i].mag));
            $display("vec %0d x=%0d y=%0d sq_din=%0h mag=%0d", i, vt[i].x, vt[i].y, sq_din, mag);
        end

        // Back-to-back fill with the core held busy
        hold_busy = 1'b1; m0 = mag_q.size(); s0 = n_start;
        for (int i = 0; i < 4; i++) begin
            send(16'(bx[i]), 16'(by[i]), ok, waited);
            check("b2b_accept_immediate", {30'd0, ok, waited == 0}, 32'd3);
        end
        in_valid = 1'b1; in_x = 16'd7; in_y = 16'd7;
        for (int i = 0; i < 4; i++) begin
            check("b2b_full_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_no_issue_while_busy", 32'(n_start - s0), 0);
        hold_busy = 1'b0;
        wait_mags(m0 + 4, 200);
        tick(10);
        check("b2b_total_mags", 32'(mag_q.size() - m0), 4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_mag_order", (mag_q.size() > m0 + i) ? 32'(mag_q[m0 + i]) : 32'hFFFF_FFFF, 32'(bm[i]));
        end
        $display("b2b mags %0d %0d %0d %0d", bm[0], bm[1], bm[2], bm[3]);

        // Randomized stream against the reference model
        m0 = mag_q.size(); d0 = din_q.size();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ($urandom_range(0, 5) == 0) rx = 16'h8000;
            send(rx, ry, ok, waited);
            in_valid = 1'b0;
            check("rnd_accept", 32'(ok), 1);
            if (ok) exp_q.push_back(model_sum(rx, ry));
            if ($urandom_range(0, 4) == 0) begin
                hold_busy = 1'b1;
                tick(int'($urandom_range(1, 8)));
                hold_busy = 1'b0;
            end
            tick(int'($urandom_range(0, 3)));
        end
        wait_mags(m0 + exp_q.size(), 2000);
        for (int i = 0; i < exp_q.size(); i++) begin
            check("rnd_sq_din", (din_q.size() > d0 + i) ? din_q[d0 + i] : 32'hFFFF_FFFF, exp_q[i]);
            check("rnd_mag", (mag_q.size() > m0 + i) ? 32'(mag_q[m0 + i]) : 32'hFFFF_FFFF,
                  32'(isqrt(longint'(exp_q[i]))));
            $display("rnd %0d sum=%0d mag=%0d", i, exp_q[i], isqrt(longint'(exp_q[i])));
        end

        // Reset while waiting on the core with two operands still queued
        core_lat = 20; s0 = n_start;
        send(16'd1, 16'd1, ok, waited);
        send(16'd2, 16'd2, ok, waited);
        send(16'd3, 16'd3, ok, waited);
        in_valid = 1'b0;
        k = 0;
        while (n_start == s0 && k < 50) begin tick(); k++; end
        tick(3);
        check("rstmid_one_issued", 32'(n_start - s0), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_in_ready", 32'(in_ready), 0);
        check("rstmid_sq_start", 32'(sq_start), 0);
        check("rstmid_sq_din", sq_din, 0);
        check("rstmid_mag", 32'(mag), 0);
        check("rstmid_mag_valid", 32'(mag_valid), 0);
        check("rstmid_timeout_err", 32'(timeout_err), 0);
        tick(2);
        rst_n = 1'b1;
        m0 = mag_q.size(); s0 = n_start;
        tick(40);
        check("rstmid_no_late_mag", 32'(mag_q.size() - m0), 0);
        check("rstmid_queue_dropped", 32'(n_start - s0), 0);
        check("rstmid_mag_still_zero", 32'(mag), 0);
        check("rstmid_in_ready_after", 32'(in_ready), 1);
        $display("reset mid-operation: pending operands dropped");
        core_lat = 0;

`ifdef MAG_FEEDER_TIMEOUT_EN
        // Watchdog: the core ignores the first operand entirely
        core_en = 1'b0; s0 = n_start; m0 = mag_q.size(); t0 = n_to;
        send(16'd5, 16'd12, ok, waited);
        send(16'd8, 16'd15, ok, waited);
        in_valid = 1'b0;
        k = 0;
        while (n_to == t0 && k < 400) begin tick(); k++; end
        core_en = 1'b1;
        check("to_pulse_count", 32'(n_to - t0), 1);
        check("to_delay", 32'(to_cyc - start_cyc), 255);
        wait_mags(m0 + 1, 100);
        tick(5);
        check("to_next_issued_after", 32'(start_cyc > to_cyc), 1);
        check("to_starts", 32'(n_start - s0), 2);
        check("to_mag_second_only", (mag_q.size() > m0) ? 32'(mag_q[m0]) : 32'hFFFF_FFFF, 17);
        $display("timeout at cycle %0d, next operand issued at %0d", to_cyc, start_cyc);
        check("timeout_total", 32'(n_to), 1);
`else
        // No watchdog: a very slow core still completes
        core_lat = 300; m0 = mag_q.size();
        send(16'd5, 16'd12, ok, waited);
        in_valid = 1'b0;
        wait_mags(m0 + 1, 400);
        check("slow_core_mag", (mag_q.size() > m0) ? 32'(mag_q[m0]) : 32'hFFFF_FFFF, 13);
        $display("slow core result mag=%0d", mag);
        core_lat = 0;
        check("timeout_total", 32'(n_to), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
